// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port arbiter: merges single-cycle ALU results with queued LSU results,
// one registered write per cycle, with aging so LSU results cannot starve.
module reg_writeback_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ALU_VALID,
  output logic                    ALU_READY,
  input  logic [ADDR_WIDTH-1:0]   ALU_ADDRESS,
  input  logic [DATA_WIDTH-1:0]   ALU_DATA,
  input  logic                    LSU_VALID,
  output logic                    LSU_READY,
  input  logic [ADDR_WIDTH-1:0]   LSU_ADDRESS,
  input  logic [DATA_WIDTH-1:0]   LSU_DATA,
  output logic                    WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0]   WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0]   WRITE_DATA,
  output logic [$clog2(DEPTH):0]  FIFO_COUNT,
  output logic                    BUSY
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [StW-1:0]  StarveC = StW'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [StW-1:0]        starve_q, starve_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic force_pri;
  logic fifo_ne;
  logic alu_wr;
  logic lsu_push;
  logic pop;

  // Readies depend only on registered state, never on the VALIDs.
  assign force_pri = (starve_q == StarveC);
  assign ALU_READY = ~force_pri;
  assign LSU_READY = (count_q < DepthC);
  assign fifo_ne   = (count_q != '0);

  // Writes to x0 complete the handshake but are discarded.
  assign alu_wr   = ALU_VALID & ~force_pri & (ALU_ADDRESS != '0);
  assign lsu_push = LSU_VALID & LSU_READY & (LSU_ADDRESS != '0);
  assign pop      = fifo_ne & (force_pri | ~alu_wr);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pop) begin
      we_d    = 1'b1;
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
    end else if (alu_wr) begin
      we_d    = 1'b1;
      waddr_d = ALU_ADDRESS;
      wdata_d = ALU_DATA;
    end
  end

  always_comb begin
    wr_ptr_d = lsu_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({lsu_push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!fifo_ne || pop) begin
      starve_d = '0;
    end else if (starve_q != StarveC) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count and pointers.
  always_ff @(posedge CLK) begin
    if (!RESET && lsu_push) begin
      fifo_addr_q[wr_ptr_q] <= LSU_ADDRESS;
      fifo_data_q[wr_ptr_q] <= LSU_DATA;
    end
  end

  assign WRITE_ENABLE  = we_q;
  assign WRITE_ADDRESS = waddr_q;
  assign WRITE_DATA    = wdata_q;
  assign FIFO_COUNT    = count_q;
  assign BUSY          = fifo_ne | we_q;

endmodule
